esc_pwm_engine: RTL and testbench

//  N-channel ESC PWM generator with a parametrised frame, pulse range and rate scaling.

---
 rtl/esc_pwm_engine_pkg.sv | 46 ++++
 rtl/esc_pwm_channel.sv | 112 +++++++++++
 rtl/esc_pwm_engine.sv | 96 +++++++++
 tb/tb_esc_pwm_engine.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/esc_pwm_engine_pkg.sv
// ---------------------------------------------------------------------------
// esc_pwm_engine_pkg
//   Shared definitions for the ESC PWM engine slice.
//   - Default frame/pulse constants used as parameter defaults by the
//     engine and channel modules.
//   - width_t: the 16-bit microsecond pulse-width type.
//   - width_evt_e: the event that updates a channel's applied width.
//   - slew_toward(): one-frame slew step of a width toward its target.
// ---------------------------------------------------------------------------
package esc_pwm_engine_pkg;

    localparam int PWM_NUM_CH           = 4;
    localparam int MOTOR_RATE_BIT_WIDTH = 8;
    localparam int PWM_SCALE_SHIFT      = 2;
    localparam int PWM_PERIOD_US        = 2500;
    localparam int MIN_PWM_TIME_HIGH_US = 1000;
    localparam int MAX_PWM_TIME_HIGH_US = 2000;
    localparam int PWM_SLEW_US          = 50;

    localparam int WIDTH_W = 16;

    typedef logic [WIDTH_W-1:0] width_t;

    // What happens to a channel's applied width on a given clock edge.
    typedef enum logic [1:0] {
        WIDTH_HOLD   = 2'd0,  // mid-frame: width is frozen
        WIDTH_FRAME  = 2'd1,  // frame boundary: slew toward the new target
        WIDTH_DISARM = 2'd2   // mid-frame disarm: snap to the minimum pulse
    } width_evt_e;

    // Move cur toward tgt by at most step; a step of 0 jumps straight to tgt.
    function automatic width_t slew_toward(input width_t cur,
                                           input width_t tgt,
                                           input width_t step);
        width_t result;
        if (step == '0) begin
            result = tgt;
        end else if (tgt > cur) begin
            result = ((tgt - cur) > step) ? (cur + step) : tgt;
        end else begin
            result = ((cur - tgt) > step) ? (cur - step) : tgt;
        end
        return result;
    endfunction

endpackage : esc_pwm_engine_pkg

// File: rtl/esc_pwm_channel.sv
// ---------------------------------------------------------------------------
// esc_pwm_channel
//   One ESC output channel: target computation and clamp, per-frame slew
//   register, enable latch and the registered pulse compare.
// Ports
//   us_clk      in   1        1 MHz clock
//   resetn      in   1        asynchronous, active-low reset
//   rate        in   RATE_W   mixer rate for this channel
//   ch_enable   in   1        channel enable, sampled at the frame boundary
//   armed       in   1        raw armed input; its value at the boundary
//                             decides whether the new frame follows rate
//   period_cnt  in   CNT_W    shared frame counter
//   boundary    in   1        high in the cycle whose edge starts a frame
//   disarm      in   1        high in the cycle whose edge applies a
//                             mid-frame disarm
//   pwm_out     out  1        registered ESC pulse
//   width_mon   out  16       applied pulse width in us
// ---------------------------------------------------------------------------
module esc_pwm_channel
    import esc_pwm_engine_pkg::*;
#(
    parameter int RATE_W      = MOTOR_RATE_BIT_WIDTH,
    parameter int SCALE_SHIFT = PWM_SCALE_SHIFT,
    parameter int MIN_HIGH_US = MIN_PWM_TIME_HIGH_US,
    parameter int MAX_HIGH_US = MAX_PWM_TIME_HIGH_US,
    parameter int SLEW_US     = PWM_SLEW_US,
    parameter int CNT_W       = 12
) (
    input  logic              us_clk,
    input  logic              resetn,
    input  logic [RATE_W-1:0] rate,
    input  logic              ch_enable,
    input  logic              armed,
    input  logic [CNT_W-1:0]  period_cnt,
    input  logic              boundary,
    input  logic              disarm,
    output logic              pwm_out,
    output logic [15:0]       width_mon
);

    localparam width_t MIN_W  = width_t'(MIN_HIGH_US);
    localparam width_t MAX_W  = width_t'(MAX_HIGH_US);
    localparam width_t SLEW_W = width_t'(SLEW_US);

    width_t           width_q;
    logic             en_q;

    width_t           rate_scaled;
    logic [WIDTH_W:0] tgt_sum;
    width_t           tgt;
    width_evt_e       evt;
    width_t           width_d;
    logic             en_d;
    logic [CNT_W-1:0] next_cnt;
    logic             pwm_d;

    // Target pulse width. The sum is carried one bit wider than width_t so
    // the clamp sees the true value instead of a wrapped one.
    always_comb begin
        rate_scaled = width_t'(rate) << SCALE_SHIFT;
        tgt_sum     = {1'b0, MIN_W} + {1'b0, rate_scaled};
        tgt         = (tgt_sum > {1'b0, MAX_W}) ? MAX_W : tgt_sum[WIDTH_W-1:0];
    end

    always_comb begin
        if (boundary) begin
            evt = WIDTH_FRAME;
        end else if (disarm) begin
            evt = WIDTH_DISARM;
        end else begin
            evt = WIDTH_HOLD;
        end
    end

    // NOTE: every signal assigned in always_comb gets a value on every path
    // (default first or a default case arm); a missed path infers a latch.
    always_comb begin
        width_d = width_q;
        unique case (evt)
            // Disarm at the boundary skips the slew and starts at the minimum.
            WIDTH_FRAME:  width_d = armed ? slew_toward(width_q, tgt, SLEW_W) : MIN_W;
            WIDTH_DISARM: width_d = MIN_W;
            default:      width_d = width_q;
        endcase
    end

    // The compare looks at the counter value of the cycle being entered, so
    // the registered pulse rises on the boundary edge and lasts exactly
    // width cycles with no combinational glitch on the pin.
    always_comb begin
        en_d     = boundary ? ch_enable : en_q;
        next_cnt = boundary ? '0 : (period_cnt + CNT_W'(1));
        pwm_d    = en_d && (width_d > width_t'(next_cnt));
    end

    // NOTE: sequential state uses non-blocking (<=) assignments only, so all
    // registers update together from the values before the edge.
    always_ff @(posedge us_clk or negedge resetn) begin
        if (!resetn) begin
            width_q <= MIN_W;
            en_q    <= 1'b0;
            pwm_out <= 1'b0;
        end else begin
            width_q <= width_d;
            en_q    <= en_d;
            pwm_out <= pwm_d;
        end
    end

    assign width_mon = width_q;

endmodule : esc_pwm_channel

// File: rtl/esc_pwm_engine.sv
// ---------------------------------------------------------------------------
// esc_pwm_engine
//   N-channel ESC PWM generator. Owns the frame counter, the frame_start
//   strobe and the armed state; each channel is an esc_pwm_channel.
// Ports
//   us_clk       in   1               1 MHz clock
//   resetn       in   1               asynchronous, active-low reset
//   rates        in   NUM_CH*RATE_W   channel i at [i*RATE_W +: RATE_W]
//   ch_enable    in   NUM_CH          1 = channel emits pulses
//   armed        in   1               1 = follow rates, 0 = minimum pulse
//   pwm_out      out  NUM_CH          ESC PWM lines, registered
//   frame_start  out  1               one-cycle strobe in frame cycle 0
//   width_mon    out  NUM_CH*16       applied pulse widths in us
// ---------------------------------------------------------------------------
module esc_pwm_engine
    import esc_pwm_engine_pkg::*;
#(
    parameter int NUM_CH      = PWM_NUM_CH,
    parameter int RATE_W      = MOTOR_RATE_BIT_WIDTH,
    parameter int SCALE_SHIFT = PWM_SCALE_SHIFT,
    parameter int PERIOD_US   = PWM_PERIOD_US,
    parameter int MIN_HIGH_US = MIN_PWM_TIME_HIGH_US,
    parameter int MAX_HIGH_US = MAX_PWM_TIME_HIGH_US,
    parameter int SLEW_US     = PWM_SLEW_US
) (
    input  logic                     us_clk,
    input  logic                     resetn,
    input  logic [NUM_CH*RATE_W-1:0] rates,
    input  logic [NUM_CH-1:0]        ch_enable,
    input  logic                     armed,
    output logic [NUM_CH-1:0]        pwm_out,
    output logic                     frame_start,
    output logic [NUM_CH*16-1:0]     width_mon
);

    localparam int CNT_W = $clog2(PERIOD_US);

    if (!((MIN_HIGH_US <= MAX_HIGH_US) && (MAX_HIGH_US < PERIOD_US) &&
          (PERIOD_US <= 65535))) begin : g_param_error
        $error("esc_pwm_engine: need MIN_HIGH_US <= MAX_HIGH_US < PERIOD_US <= 65535");
    end

    logic [CNT_W-1:0] period_cnt;
    logic             armed_q;
    logic             boundary;
    logic             disarm;

    // Reset parks the counter on the last frame cycle, so the first edge
    // after reset release is a frame boundary.
    assign boundary = (period_cnt == CNT_W'(PERIOD_US - 1));

    // A mid-frame disarm fires once, on the first edge that sees armed low
    // while the current frame is still running armed. On a boundary edge the
    // channels handle armed directly.
    assign disarm = armed_q && !armed && !boundary;

    always_ff @(posedge us_clk or negedge resetn) begin
        if (!resetn) begin
            period_cnt  <= CNT_W'(PERIOD_US - 1);
            frame_start <= 1'b0;
            armed_q     <= 1'b0;
        end else begin
            period_cnt  <= boundary ? '0 : (period_cnt + CNT_W'(1));
            frame_start <= boundary;
            // Arming only takes effect at a boundary; disarming is immediate.
            if (boundary) begin
                armed_q <= armed;
            end else if (!armed) begin
                armed_q <= 1'b0;
            end
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        esc_pwm_channel #(
            .RATE_W      (RATE_W),
            .SCALE_SHIFT (SCALE_SHIFT),
            .MIN_HIGH_US (MIN_HIGH_US),
            .MAX_HIGH_US (MAX_HIGH_US),
            .SLEW_US     (SLEW_US),
            .CNT_W       (CNT_W)
        ) u_channel (
            .us_clk     (us_clk),
            .resetn     (resetn),
            .rate       (rates[i*RATE_W +: RATE_W]),
            .ch_enable  (ch_enable[i]),
            .armed      (armed),
            .period_cnt (period_cnt),
            .boundary   (boundary),
            .disarm     (disarm),
            .pwm_out    (pwm_out[i]),
            .width_mon  (width_mon[i*16 +: 16])
        );
    end

endmodule : esc_pwm_engine

// File: tb/tb_esc_pwm_engine.sv
// ---------------------------------------------------------------------------
// tb_esc_pwm_engine
//   Two engines with default parameters run side by side on one clock:
//   dut_a slews 50 us per frame, dut_b has slewing disabled. A frame-by-frame
//   vector table drives both; hand-written sequences cover mid-frame disarm,
//   re-arm and reset.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_esc_pwm_engine;

    localparam int PERIOD = 2500;
    localparam int NV     = 26;

    typedef struct packed {
        logic [31:0]      rates_a;
        logic [31:0]      rates_b;
        logic [3:0]       en_a;
        logic [3:0]       en_b;
        logic             armed;
        logic [3:0][15:0] wid_a;
        logic [3:0][15:0] wid_b;
    } vec_t;

    vec_t vecs [NV];

    logic        us_clk = 1'b0;
    logic        resetn;
    logic [31:0] rates_a, rates_b;
    logic [3:0]  ch_enable_a, ch_enable_b;
    logic        armed;
    logic [3:0]  pwm_out_a, pwm_out_b;
    logic        frame_start_a, frame_start_b;
    logic [63:0] width_mon_a, width_mon_b;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 us_clk = ~us_clk;

    esc_pwm_engine #(.SLEW_US(50)) u_dut_a (
        .us_clk      (us_clk),
        .resetn      (resetn),
        .rates       (rates_a),
        .ch_enable   (ch_enable_a),
        .armed       (armed),
        .pwm_out     (pwm_out_a),
        .frame_start (frame_start_a),
        .width_mon   (width_mon_a)
    );

    esc_pwm_engine #(.SLEW_US(0)) u_dut_b (
        .us_clk      (us_clk),
        .resetn      (resetn),
        .rates       (rates_b),
        .ch_enable   (ch_enable_b),
        .armed       (armed),
        .pwm_out     (pwm_out_b),
        .frame_start (frame_start_b),
        .width_mon   (width_mon_b)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        rates_a     = v.rates_a;
        rates_b     = v.rates_b;
        ch_enable_a = v.en_a;
        ch_enable_b = v.en_b;
        armed       = v.armed;
    endtask

    // Entered at the negedge of frame cycle 0; leaves at the negedge of the
    // next frame's cycle 0. Next frame's inputs go in mid-pulse (cycle 500).
    task automatic run_vec_frame(input int k);
        int hi_a [4];
        int hi_b [4];
        int fs_n;
        fs_n = 0;
        for (int c = 0; c < 4; c++) begin
            hi_a[c] = 0;
            hi_b[c] = 0;
        end
        for (int i = 0; i < PERIOD; i++) begin
            if (i > 0) @(negedge us_clk);
            if (i == 0) check($sformatf("f%0d frame_start", k), {62'd0, frame_start_b, frame_start_a}, 64'd3);
            fs_n += int'(frame_start_a);
            for (int c = 0; c < 4; c++) begin
                hi_a[c] += int'(pwm_out_a[c]);
                hi_b[c] += int'(pwm_out_b[c]);
            end
            if (i == 1) begin
                check($sformatf("f%0d width_mon_a", k), width_mon_a, vecs[k].wid_a);
                check($sformatf("f%0d width_mon_b", k), width_mon_b, vecs[k].wid_b);
            end
            if (i == 500 && k + 1 < NV) apply(vecs[k+1]);
        end
        check($sformatf("f%0d strobes per frame", k), fs_n, 1);
        for (int c = 0; c < 4; c++) begin
            check($sformatf("f%0d a ch%0d high", k, c), hi_a[c],
                  vecs[k].en_a[c] ? int'(vecs[k].wid_a[c]) : 0);
            check($sformatf("f%0d b ch%0d high", k, c), hi_b[c],
                  vecs[k].en_b[c] ? int'(vecs[k].wid_b[c]) : 0);
        end
        @(negedge us_clk);
    endtask

    initial begin
        int hi [4];
        int w;

        // Vector table: entry k is in force at the boundary starting frame k.
        for (int k = 0; k < NV; k++) begin
            vecs[k].armed   = 1'b1;
            vecs[k].rates_a = 32'h0;
            vecs[k].en_a    = 4'hF;
            vecs[k].wid_a   = {4{16'd1000}};
            vecs[k].rates_b = {8'h00, 8'h00, 8'h40, 8'hFF};
            vecs[k].en_b    = (k >= 2 && k < 14) ? 4'b1011 : 4'hF;
            vecs[k].wid_b   = {16'd1000, 16'd1000, 16'd1256, 16'd2000};
            if (k >= 6) begin
                vecs[k].rates_b = {8'h10, 8'h00, 8'hFF, 8'hFF};
                vecs[k].wid_b   = {16'd1064, 16'd1000, 16'd2000, 16'd2000};
            end
            if (k >= 10) begin
                vecs[k].rates_b = {8'hFA, 8'h00, 8'hFF, 8'hFF};
                vecs[k].wid_b   = {16'd2000, 16'd1000, 16'd2000, 16'd2000};
            end
            if (k >= 14) begin
                vecs[k].rates_b = {8'hFB, 8'h00, 8'hFF, 8'hFF};
            end
        end
        for (int j = 0; j < 20; j++) begin
            vecs[2+j].rates_a = {4{8'hFF}};
            vecs[2+j].wid_a   = {4{16'(1050 + 50*j)}};
        end
        for (int j = 0; j < 4; j++) begin
            vecs[22+j].rates_a = {4{8'hC8}};
            vecs[22+j].wid_a   = {4{16'(1950 - 50*j)}};
        end

        // Reset state.
        resetn = 1'b0;
        apply(vecs[0]);
        repeat (3) @(negedge us_clk);
        check("reset pwm_out", {pwm_out_b, pwm_out_a}, 64'd0);
        check("reset frame_start", {frame_start_b, frame_start_a}, 64'd0);
        check("reset width_mon_a", width_mon_a, {4{16'd1000}});
        check("reset width_mon_b", width_mon_b, {4{16'd1000}});
        resetn = 1'b1;

        w = 0;
        while (frame_start_a !== 1'b1 && w < PERIOD + 4) begin
            @(negedge us_clk);
            w++;
        end
        check("first frame_start after release", w, 1);

        for (int k = 0; k < NV; k++) run_vec_frame(k);

        // Disarm at period_cnt 1500 while widths are 1800.
        rates_a = {4{8'hFF}};
        for (int c = 0; c < 4; c++) hi[c] = 0;
        for (int i = 0; i < PERIOD; i++) begin
            if (i > 0) @(negedge us_clk);
            for (int c = 0; c < 4; c++) hi[c] += int'(pwm_out_a[c]);
            if (i == 1) check("disarm frame width", width_mon_a, {4{16'd1800}});
            if (i == 1500) begin
                check("pwm high before disarm", pwm_out_a, 64'hF);
                armed = 1'b0;
            end
            if (i == 1501) begin
                check("pwm low on disarm edge", pwm_out_a, 64'h0);
                check("width forced on disarm", width_mon_a, {4{16'd1000}});
            end
        end
        for (int c = 0; c < 4; c++) check($sformatf("disarm ch%0d high", c), hi[c], 1501);
        @(negedge us_clk);

        // Disarmed frame with full rate; re-arm mid-frame has no effect yet.
        for (int c = 0; c < 4; c++) hi[c] = 0;
        for (int i = 0; i < PERIOD; i++) begin
            if (i > 0) @(negedge us_clk);
            for (int c = 0; c < 4; c++) hi[c] += int'(pwm_out_a[c]);
            if (i == 0) check("disarmed frame_start", frame_start_a, 64'd1);
            if (i == 1) check("disarmed width", width_mon_a, {4{16'd1000}});
            if (i == 500) armed = 1'b1;
            if (i == PERIOD - 1) check("rearm waits for boundary", width_mon_a, {4{16'd1000}});
        end
        for (int c = 0; c < 4; c++) check($sformatf("disarmed ch%0d high", c), hi[c], 1000);
        @(negedge us_clk);

        // First armed frame slews up from the minimum.
        for (int c = 0; c < 4; c++) hi[c] = 0;
        for (int i = 0; i < PERIOD; i++) begin
            if (i > 0) @(negedge us_clk);
            for (int c = 0; c < 4; c++) hi[c] += int'(pwm_out_a[c]);
            if (i == 1) check("rearmed width", width_mon_a, {4{16'd1050}});
        end
        for (int c = 0; c < 4; c++) check($sformatf("rearmed ch%0d high", c), hi[c], 1050);
        @(negedge us_clk);

        // Reset in the middle of a pulse.
        repeat (300) @(negedge us_clk);
        check("pwm high before reset", pwm_out_a, 64'hF);
        resetn = 1'b0;
        #1;
        check("reset async pwm_out", {pwm_out_b, pwm_out_a}, 64'd0);
        check("reset async frame_start", {frame_start_b, frame_start_a}, 64'd0);
        check("reset async width_mon_a", width_mon_a, {4{16'd1000}});
        repeat (2) @(negedge us_clk);
        resetn = 1'b1;
        #1;
        check("released width_mon_a", width_mon_a, {4{16'd1000}});
        @(negedge us_clk);
        check("frame_start on first edge", frame_start_a, 64'd1);
        check("pwm rises on first edge", pwm_out_a, 64'hF);
        check("first frame width after reset", width_mon_a, {4{16'd1050}});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_esc_pwm_engine
